regfile_writeback_scheduler: RTL and testbench

- Shares the COMMIT_PORTS write ports of the banked register file between NUM_WB_UNITS writeback requesters (ALU, mul/div, load/store, CSR).
- Owns the live value table (LVT). The LVT records, per architectural register, which bank holds the newest value, and the block drives the bank-select used by read muxing.
- Sits inside the register-file/writeback block, between execution-unit writeback outputs and the per-bank register file storage.

---
 rtl/regfile_writeback_scheduler_pkg.sv | 22 ++
 rtl/regfile_writeback_scheduler_rr_multi_grant.sv | 59 +++++
 rtl/regfile_writeback_scheduler.sv | 156 +++++++++++++++
 tb/tb_regfile_writeback_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_scheduler_pkg.sv
// Shared types and configuration for the register-file writeback scheduler.
// Optional statistics counters are enabled with WB_SCHED_STATS_EN.
package regfile_writeback_scheduler_pkg;

   localparam int CFG_COMMIT_PORTS      = 2;
   localparam int CFG_LOG2_COMMIT_PORTS = (CFG_COMMIT_PORTS > 1) ? $clog2(CFG_COMMIT_PORTS) : 1;
   localparam int NUM_ARCH_REGS         = 32;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_request_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } rf_write_t;

   typedef logic [CFG_LOG2_COMMIT_PORTS-1:0] lvt_entry_t;

endpackage

// File: rtl/regfile_writeback_scheduler_rr_multi_grant.sv
// Round-robin scanner: grants up to P write ports to valid requesters starting at ptr,
// deferring any requester whose rd collides with one already accepted this cycle.
module rr_multi_grant #(
   parameter int N    = 4,
   parameter int P    = 2,
   parameter int IDXW = 2,
   parameter int CW   = 3
) (
   input  logic [N-1:0]         valid,
   input  logic [N-1:0]         needs_port,
   input  logic [N-1:0][N-1:0]  coll,
   input  logic [IDXW-1:0]      ptr,
   output logic [N-1:0]         ack,
   output logic [P-1:0][N-1:0]  port_gnt,
   output logic                 any_ack,
   output logic [IDXW-1:0]      last_idx,
   output logic [CW-1:0]        defer_cnt
);

   int   idx;
   int   ports_used;
   logic blocked;
   logic full;

   // Scanning stops once every port is taken, so the pointer never jumps
   // past a requester that was only refused for lack of a port.
   always_comb begin
      ack        = '0;
      port_gnt   = '0;
      any_ack    = 1'b0;
      last_idx   = '0;
      defer_cnt  = '0;
      idx        = 0;
      ports_used = 0;
      blocked    = 1'b0;
      full       = 1'b0;
      for (int s = 0; s < N; s++) begin
         idx     = (int'(ptr) + s) % N;
         blocked = 1'b0;
         for (int j = 0; j < N; j++)
            if (ack[j] && coll[idx][j]) blocked = 1'b1;
         if (valid[idx] && !full) begin
            if (blocked) begin
               defer_cnt = defer_cnt + CW'(1);
            end else begin
               ack[idx] = 1'b1;
               any_ack  = 1'b1;
               last_idx = IDXW'(idx);
               if (needs_port[idx]) begin
                  port_gnt[ports_used][idx] = 1'b1;
                  ports_used = ports_used + 1;
                  if (ports_used == P) full = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/regfile_writeback_scheduler.sv
// Writeback port scheduler and live value table for the banked register file.
// Define WB_SCHED_STATS_EN to add stall/collision counters and their outputs.
module regfile_writeback_scheduler
   import regfile_writeback_scheduler_pkg::*;
#(
   parameter int NUM_WB_UNITS      = 4,
   parameter int COMMIT_PORTS      = CFG_COMMIT_PORTS,
   parameter int LOG2_COMMIT_PORTS = (COMMIT_PORTS > 1) ? $clog2(COMMIT_PORTS) : 1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_WB_UNITS-1:0]                 wb_valid,
   input  logic [NUM_WB_UNITS-1:0][4:0]            wb_rd,
   input  logic [NUM_WB_UNITS-1:0][31:0]           wb_data,
   output logic [NUM_WB_UNITS-1:0]                 wb_ack,
   output logic [COMMIT_PORTS-1:0]                 rf_we,
   output logic [COMMIT_PORTS-1:0][4:0]            rf_waddr,
   output logic [COMMIT_PORTS-1:0][31:0]           rf_wdata,
   input  logic [4:0]                              rs1_addr,
   input  logic [4:0]                              rs2_addr,
   output logic [LOG2_COMMIT_PORTS-1:0]            rs1_bank,
   output logic [LOG2_COMMIT_PORTS-1:0]            rs2_bank,
   output logic [31:0][LOG2_COMMIT_PORTS-1:0]      sel_bank
`ifdef WB_SCHED_STATS_EN
   ,
   output logic [31:0]                             stat_stall_cycles,
   output logic [31:0]                             stat_collisions
`endif
);

   localparam int IDXW = (NUM_WB_UNITS > 1) ? $clog2(NUM_WB_UNITS) : 1;
   localparam int CW   = $clog2(NUM_WB_UNITS + 1);

   wb_request_t [NUM_WB_UNITS-1:0]                  req;
   logic [NUM_WB_UNITS-1:0]                         needs_port;
   logic [NUM_WB_UNITS-1:0][NUM_WB_UNITS-1:0]       coll;
   logic [NUM_WB_UNITS-1:0]                         ack;
   logic [COMMIT_PORTS-1:0][NUM_WB_UNITS-1:0]       port_gnt;
   logic                                            any_ack;
   logic [IDXW-1:0]                                 last_idx;
   logic [IDXW-1:0]                                 rr_ptr;
   wb_request_t [COMMIT_PORTS-1:0]                  port_req;
   logic [COMMIT_PORTS-1:0]                         port_we;
   rf_write_t [COMMIT_PORTS-1:0]                    rf_q;
   logic [NUM_ARCH_REGS-1:0][LOG2_COMMIT_PORTS-1:0] lvt_q;
`ifdef WB_SCHED_STATS_EN
   logic [CW-1:0]                                   defer_cnt;
   logic [32:0]                                     coll_sum;
`endif

   // rd 0 is discarded, so it never needs a port nor collides with anything.
   always_comb begin
      for (int i = 0; i < NUM_WB_UNITS; i++) begin
         req[i].rd     = wb_rd[i];
         req[i].data   = wb_data[i];
         needs_port[i] = (wb_rd[i] != 5'd0);
         for (int j = 0; j < NUM_WB_UNITS; j++)
            coll[i][j] = (i != j) && needs_port[i] && (wb_rd[i] == wb_rd[j]);
      end
   end

   rr_multi_grant #(
      .N    (NUM_WB_UNITS),
      .P    (COMMIT_PORTS),
      .IDXW (IDXW),
      .CW   (CW)
   ) u_grant (
      .valid      (wb_valid),
      .needs_port (needs_port),
      .coll       (coll),
      .ptr        (rr_ptr),
      .ack        (ack),
      .port_gnt   (port_gnt),
      .any_ack    (any_ack),
      .last_idx   (last_idx)
`ifdef WB_SCHED_STATS_EN
      ,
      .defer_cnt  (defer_cnt)
`else
      ,
      .defer_cnt  ()
`endif
   );

   assign wb_ack = rst ? '0 : ack;

   always_comb begin
      port_req = '0;
      port_we  = '0;
      for (int p = 0; p < COMMIT_PORTS; p++)
         for (int i = 0; i < NUM_WB_UNITS; i++)
            if (port_gnt[p][i]) begin
               port_we[p]  = 1'b1;
               port_req[p] = req[i];
            end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_q   <= '0;
         rr_ptr <= '0;
      end else begin
         for (int p = 0; p < COMMIT_PORTS; p++) begin
            rf_q[p].we    <= port_we[p];
            rf_q[p].waddr <= port_req[p].rd;
            rf_q[p].wdata <= port_req[p].data;
         end
         if (any_ack)
            rr_ptr <= (last_idx == IDXW'(NUM_WB_UNITS - 1)) ? '0 : last_idx + IDXW'(1);
      end
   end

   // With a single bank every value lives in bank 0, so the table is constant.
   generate
      if (COMMIT_PORTS == 1) begin : g_no_lvt
         assign lvt_q = '0;
      end else begin : g_lvt
         always_ff @(posedge clk) begin
            if (rst) begin
               lvt_q <= '0;
            end else begin
               for (int p = 0; p < COMMIT_PORTS; p++)
                  if (port_we[p]) lvt_q[port_req[p].rd] <= LOG2_COMMIT_PORTS'(p);
            end
         end
      end
   endgenerate

   always_comb begin
      for (int p = 0; p < COMMIT_PORTS; p++) begin
         rf_we[p]    = rf_q[p].we;
         rf_waddr[p] = rf_q[p].waddr;
         rf_wdata[p] = rf_q[p].wdata;
      end
   end

   assign rs1_bank = lvt_q[rs1_addr];
   assign rs2_bank = lvt_q[rs2_addr];
   assign sel_bank = lvt_q;

`ifdef WB_SCHED_STATS_EN
   assign coll_sum = {1'b0, stat_collisions} + 33'(defer_cnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall_cycles <= '0;
         stat_collisions   <= '0;
      end else begin
         if (|(wb_valid & ~ack) && (stat_stall_cycles != '1))
            stat_stall_cycles <= stat_stall_cycles + 32'd1;
         stat_collisions <= coll_sum[32] ? '1 : coll_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_regfile_writeback_scheduler.sv
// Directed and randomized bench for regfile_writeback_scheduler against a queue-based model.
module tb_regfile_writeback_scheduler;

   localparam int N  = 4;
   localparam int P  = 2;
   localparam int LW = 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         wb_valid;
   logic [N-1:0][4:0]    wb_rd;
   logic [N-1:0][31:0]   wb_data;
   logic [N-1:0]         wb_ack;
   logic [P-1:0]         rf_we;
   logic [P-1:0][4:0]    rf_waddr;
   logic [P-1:0][31:0]   rf_wdata;
   logic [4:0]           rs1_addr, rs2_addr;
   logic [LW-1:0]        rs1_bank, rs2_bank;
   logic [31:0][LW-1:0]  sel_bank;
`ifdef WB_SCHED_STATS_EN
   logic [31:0]          stat_stall_cycles, stat_collisions;
`endif

   regfile_writeback_scheduler #(.NUM_WB_UNITS(N), .COMMIT_PORTS(P)) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .wb_ack   (wb_ack),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_bank (rs1_bank),
      .rs2_bank (rs2_bank),
      .sel_bank (sel_bank)
`ifdef WB_SCHED_STATS_EN
      ,
      .stat_stall_cycles (stat_stall_cycles),
      .stat_collisions   (stat_collisions)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Requester-side pending requests and the reference model state.
   bit          pend_v[N];
   logic [4:0]  pend_rd[N];
   logic [31:0] pend_data[N];
   int          m_ptr;
   int          lvt[32];
   bit          exp_we[P];
   logic [4:0]  exp_addr[P];
   logic [31:0] exp_data[P];
   logic [N-1:0] m_ack;
   int          m_port_unit[P];
   int          m_last;
   logic [N-1:0] obs_ack;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
      pend_v[i]    = 1'b1;
      pend_rd[i]   = rd;
      pend_data[i] = data;
   endtask

   // Walk requesters in round-robin order; a nonzero rd already taken this cycle
   // is deferred, rd 0 is accepted without a port, and scanning ends with the ports.
   function automatic void model_grant();
      int used;
      logic [4:0] taken[$];
      bit dup;
      int i;
      m_ack = '0;
      m_last = -1;
      used = 0;
      for (int p = 0; p < P; p++) m_port_unit[p] = -1;
      for (int s = 0; s < N; s++) begin
         i = (m_ptr + s) % N;
         if (used == P) break;
         if (!pend_v[i]) continue;
         dup = 1'b0;
         foreach (taken[k]) if (pend_rd[i] != 0 && taken[k] == pend_rd[i]) dup = 1'b1;
         if (dup) continue;
         m_ack[i] = 1'b1;
         m_last = i;
         if (pend_rd[i] != 0) begin
            m_port_unit[used] = i;
            used++;
            taken.push_back(pend_rd[i]);
         end
      end
   endfunction

   task automatic cycle(input bit do_rst);
      logic [31:0][LW-1:0] exp_sel;
      int u;
      rst = do_rst;
      for (int i = 0; i < N; i++) begin
         wb_valid[i] = pend_v[i];
         wb_rd[i]    = pend_rd[i];
         wb_data[i]  = pend_data[i];
      end
      rs1_addr = 5'($urandom);
      rs2_addr = 5'($urandom);
      #1;
      if (do_rst) begin
         m_ack = '0;
         for (int p = 0; p < P; p++) m_port_unit[p] = -1;
      end else begin
         model_grant();
      end
      obs_ack = wb_ack;
      chk("wb_ack", 64'(wb_ack), 64'(m_ack));
      chk("rs1_bank", 64'(rs1_bank), 64'(lvt[rs1_addr]));
      chk("rs2_bank", 64'(rs2_bank), 64'(lvt[rs2_addr]));
      @(posedge clk);
      #1;
      if (do_rst) begin
         foreach (lvt[r]) lvt[r] = 0;
         for (int p = 0; p < P; p++) exp_we[p] = 1'b0;
         m_ptr = 0;
      end else begin
         for (int p = 0; p < P; p++) begin
            exp_we[p] = (m_port_unit[p] >= 0);
            if (exp_we[p]) begin
               u = m_port_unit[p];
               exp_addr[p] = pend_rd[u];
               exp_data[p] = pend_data[u];
               lvt[pend_rd[u]] = p;
            end
         end
         if (m_ack != '0) m_ptr = (m_last + 1) % N;
         for (int i = 0; i < N; i++) if (m_ack[i]) pend_v[i] = 1'b0;
      end
      for (int p = 0; p < P; p++) begin
         chk($sformatf("rf_we%0d", p), 64'(rf_we[p]), 64'(exp_we[p]));
         if (exp_we[p]) begin
            chk($sformatf("rf_waddr%0d", p), 64'(rf_waddr[p]), 64'(exp_addr[p]));
            chk($sformatf("rf_wdata%0d", p), 64'(rf_wdata[p]), 64'(exp_data[p]));
         end
      end
      for (int r = 0; r < 32; r++) exp_sel[r] = LW'(lvt[r]);
      chk("sel_bank", 64'(sel_bank), 64'(exp_sel));
   endtask

   initial begin
      int cnt[N];
      int waitc[N];
      int max_wait;
      rst = 1'b1;
      wb_valid = '0;
      wb_rd = '0;
      wb_data = '0;
      rs1_addr = '0;
      rs2_addr = '0;
      m_ptr = 0;
      foreach (lvt[r]) lvt[r] = 0;
      for (int i = 0; i < N; i++) begin
         pend_v[i] = 1'b0; pend_rd[i] = '0; pend_data[i] = '0;
      end
      for (int p = 0; p < P; p++) begin
         exp_we[p] = 1'b0; exp_addr[p] = '0; exp_data[p] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      cycle(1'b1);
      chk("reset_we", 64'(rf_we), 64'(0));
      chk("reset_sel", 64'(sel_bank), 64'(0));

      // Idle after reset.
      repeat (10) cycle(1'b0);
      chk("idle_we", 64'(rf_we), 64'(0));
      chk("idle_sel", 64'(sel_bank), 64'(0));

      // Three requesters, two ports.
      set_req(0, 5'd5, 32'h1111_0005);
      set_req(1, 5'd6, 32'h1111_0006);
      set_req(2, 5'd7, 32'h1111_0007);
      cycle(1'b0);
      chk("t2_ack", 64'(obs_ack), 64'(4'b0011));
      chk("t2_we", 64'(rf_we), 64'(2'b11));
      chk("t2_addr0", 64'(rf_waddr[0]), 64'(5));
      chk("t2_addr1", 64'(rf_waddr[1]), 64'(6));
      chk("t2_sel5", 64'(sel_bank[5]), 64'(0));
      chk("t2_sel6", 64'(sel_bank[6]), 64'(1));
      cycle(1'b0);
      chk("t2_ack2", 64'(obs_ack), 64'(4'b0100));
      chk("t2_we2", 64'(rf_we), 64'(2'b01));
      chk("t2_addr2", 64'(rf_waddr[0]), 64'(7));
      chk("t2_sel7", 64'(sel_bank[7]), 64'(0));

      // Same-rd collision.
      set_req(0, 5'd9, 32'hAAAA_AAAA);
      set_req(1, 5'd9, 32'hBBBB_BBBB);
      cycle(1'b0);
      chk("t3_ack", 64'(obs_ack), 64'(4'b0001));
      chk("t3_dataA", 64'(rf_wdata[0]), 64'(32'hAAAA_AAAA));
      cycle(1'b0);
      chk("t3_ack2", 64'(obs_ack), 64'(4'b0010));
      chk("t3_dataB", 64'(rf_wdata[0]), 64'(32'hBBBB_BBBB));
      chk("t3_sel9", 64'(sel_bank[9]), 64'(0));

      // rd 0 is acked without a port.
      set_req(3, 5'd0, 32'hDEAD_0000);
      set_req(2, 5'd4, 32'h0000_0044);
      cycle(1'b0);
      chk("t4_ack", 64'(obs_ack), 64'(4'b1100));
      chk("t4_we", 64'(rf_we), 64'(2'b01));
      chk("t4_addr", 64'(rf_waddr[0]), 64'(4));
      chk("t4_sel0", 64'(sel_bank[0]), 64'(0));

      // All requesters continuously valid.
      max_wait = 0;
      for (int i = 0; i < N; i++) begin cnt[i] = 0; waitc[i] = 0; end
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < N; i++) if (!pend_v[i]) set_req(i, 5'(8 + i), $urandom);
         cycle(1'b0);
         for (int i = 0; i < N; i++) begin
            if (obs_ack[i]) begin cnt[i]++; waitc[i] = 0; end
            else waitc[i]++;
            if (waitc[i] > max_wait) max_wait = waitc[i];
         end
      end
      for (int i = 0; i < N; i++) chk($sformatf("t5_cnt%0d", i), 64'(cnt[i]), 64'(4));
      chk("t5_wait_ok", 64'(max_wait <= N), 64'(1));

      // Reset right after a granting cycle.
      cycle(1'b0);
      set_req(2, 5'd20, 32'h2020_2020);
      set_req(3, 5'd21, 32'h2121_2121);
      cycle(1'b1);
      chk("t6_ack", 64'(obs_ack), 64'(0));
      chk("t6_we", 64'(rf_we), 64'(0));
      chk("t6_sel", 64'(sel_bank), 64'(0));

      // Randomized traffic with frequent rd collisions and rd 0.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!pend_v[i] && $urandom_range(0, 1) == 1)
               set_req(i, 5'($urandom_range(0, 7)), $urandom);
         cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
